// File: rtl/ssd_scan_pkg.sv
// Shared types and glyph constants for the seven-segment scan controller.
package ssd_scan_pkg;

  localparam int unsigned SEG_W = 7;

  typedef enum logic {
    S_ON,
    S_GAP
  } scan_state_t;

  typedef enum logic [1:0] {
    SL_MSD,
    SL_LSD,
    SL_SIGN
  } scan_slot_t;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'b1000000;

  localparam logic [2:0] DIG_NONE = 3'b000;
  localparam logic [2:0] DIG_MSD  = 3'b100;
  localparam logic [2:0] DIG_LSD  = 3'b010;
  localparam logic [2:0] DIG_SIGN = 3'b001;

  // Scan order MSD -> LSD -> SIGN -> MSD; the unused encoding recovers to MSD.
  function automatic scan_slot_t next_slot(input scan_slot_t cur);
    case (cur)
      SL_MSD:  return SL_LSD;
      SL_LSD:  return SL_SIGN;
      default: return SL_MSD;
    endcase
  endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Valid/ready load port carrying a decoded two-digit value plus sign.
interface ssd_scan_ctrl_if;
  import ssd_scan_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [2*SEG_W-1:0]   in_segments;
  logic                 in_negsign;

  modport master (output in_valid, output in_segments, output in_negsign, input in_ready);
  modport slave  (input in_valid, input in_segments, input in_negsign, output in_ready);

endinterface

// File: rtl/ssd_scan_timer.sv
// Per-state cycle counter; last flags the final cycle of the current limit.
module ssd_scan_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [Width-1:0] limit,
  output logic [Width-1:0] cnt,
  output logic             last
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= clear ? '0 : cnt_q + One;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == limit - One);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Scan controller: dwell/gap FSM over MSD, LSD and sign slots, with a shadow
// register that commits only on the frame boundary.
module ssd_scan_ctrl
  import ssd_scan_pkg::*;
#(
  parameter int unsigned DWELL    = 1000,
  parameter int unsigned GAP      = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  ssd_scan_ctrl_if.slave     in_if,
  output logic [SEG_W-1:0]   seg_out,
  output logic [2:0]         dig_en,
  output logic               frame_done
);

  localparam int unsigned MaxLen = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);

  localparam logic [CntW-1:0] DwellLim = CntW'(DWELL);
  localparam logic [CntW-1:0] GapLim   = CntW'(GAP);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP - 1);

  scan_state_t          state_q, state_d;
  scan_slot_t           slot_q, slot_d;
  logic [2*SEG_W-1:0]   disp_seg_q, shd_seg_q;
  logic                 disp_neg_q, shd_neg_q;
  logic                 pending_q;

  logic [CntW-1:0]      cnt;
  logic [CntW-1:0]      limit;
  logic                 last;
  logic                 xfer;
  logic                 commit;

  assign limit = (state_q == S_ON) ? DwellLim : GapLim;

  // The timer clears itself on its last cycle, which is exactly every state transition.
  ssd_scan_timer #(
    .Width (CntW)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (last),
    .limit (limit),
    .cnt   (cnt),
    .last  (last)
  );

  assign frame_done = en && (state_q == S_GAP) && (slot_q == SL_SIGN) && (cnt == GapLast);
  assign in_if.in_ready = !pending_q;
  assign xfer   = in_if.in_valid && !pending_q;
  assign commit = frame_done && pending_q;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (en && last) begin
      if (state_q == S_ON) begin
        state_d = S_GAP;
      end else begin
        state_d = S_ON;
        slot_d  = next_slot(slot_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_GAP;
      slot_q  <= SL_SIGN;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // Commit and load are exclusive: a load needs an empty shadow, a commit a full one.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_seg_q <= '0;
      disp_neg_q <= 1'b0;
      shd_seg_q  <= '0;
      shd_neg_q  <= 1'b0;
      pending_q  <= 1'b0;
    end else if (commit) begin
      disp_seg_q <= shd_seg_q;
      disp_neg_q <= shd_neg_q;
      pending_q  <= 1'b0;
    end else if (xfer) begin
      shd_seg_q  <= in_if.in_segments;
      shd_neg_q  <= in_if.in_negsign;
      pending_q  <= 1'b1;
    end
  end

  always_comb begin
    seg_out = SEG_BLANK;
    dig_en  = DIG_NONE;
    if (en && (state_q == S_ON)) begin
      case (slot_q)
        SL_MSD: begin
          if (!(BLANK_LZ && (disp_seg_q[13:7] == SEG_ZERO))) begin
            seg_out = disp_seg_q[13:7];
            dig_en  = DIG_MSD;
          end
        end
        SL_LSD: begin
          seg_out = disp_seg_q[6:0];
          dig_en  = DIG_LSD;
        end
        SL_SIGN: begin
          seg_out = disp_neg_q ? SEG_MINUS : SEG_BLANK;
          dig_en  = DIG_SIGN;
        end
        default: begin
          seg_out = SEG_BLANK;
          dig_en  = DIG_NONE;
        end
      endcase
    end
  end

endmodule
